noc_out_port_arbiter: RTL and testbench

- Output-port controller for one router outbound link in the 2-router / 6-node NoC.
- Shares the link between NUM_IN input-port buffers using round-robin arbitration.
- Serializes the winning packet onto the 8-bit free/put/payload link, one byte per cycle.
- One instance per router output port, between the router's input buffers and the downstream node or router.

---
 rtl/noc_out_port_arbiter.sv | 132 +++++++++++++
 tb/tb_noc_out_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter
//   Output-port controller for one router outbound link. Round-robin
//   arbitration among NUM_IN input buffers. The winning head packet is
//   serialized MSB byte first onto the 8-bit free/put/payload link.
//
// Ports
//   clock, reset        : clock, async active-high reset
//   req[NUM_IN]         : buffer i has a head packet for this port
//   req_pkt[NUM_IN*PKT_W]: head packet of buffer i at [i*PKT_W +: PKT_W]
//   grant[NUM_IN]       : one-hot dequeue pulse, first SEND cycle only
//   free_outbound       : downstream can take one full packet (IDLE only)
//   put_outbound        : payload byte valid
//   payload_outbound[8] : current byte, 0 when put_outbound is low
//   busy                : high while in SEND
//   sent_count[16]      : packets fully sent since reset, wrapping

// Per-input qualifier: request sits at or above the rr pointer.
module noc_arb_lane #(
  parameter int PTR_W = 2,
  parameter int IDX   = 0
) (
  input  logic             req,
  input  logic [PTR_W-1:0] ptr,
  output logic             hi
);
  localparam logic [PTR_W-1:0] IDX_P = PTR_W'(IDX);
  assign hi = req && (IDX_P >= ptr);
endmodule

module noc_out_port_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int PKT_BYTES = 4,
  parameter int PKT_W     = 8*PKT_BYTES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       req,
  input  logic [NUM_IN*PKT_W-1:0] req_pkt,
  output logic [NUM_IN-1:0]       grant,
  input  logic                    free_outbound,
  output logic                    put_outbound,
  output logic [7:0]              payload_outbound,
  output logic                    busy,
  output logic [15:0]             sent_count
);
  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CNT_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]                   state;
  logic [PTR_W-1:0]             ptr;
  logic [CNT_W-1:0]             byte_cnt;
  logic [PKT_W-1:0]             sh_reg;
  logic [NUM_IN-1:0][PKT_W-1:0] pkt_arr;
  logic [NUM_IN-1:0]            hi_mask;
  logic [PTR_W-1:0]             win_idx;
  logic [PTR_W-1:0]             next_ptr;
  logic                         win_hit;
  logic                         arb_go;
  logic                         last_byte;

  assign pkt_arr = req_pkt;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    noc_arb_lane #(.PTR_W(PTR_W), .IDX(i)) u_lane (
      .req (req[i]),
      .ptr (ptr),
      .hi  (hi_mask[i])
    );
  end

  // Lowest request at/above ptr wins; if none, wrap to lowest overall.
  always_comb begin
    win_idx = '0;
    win_hit = 1'b0;
    for (int i = NUM_IN-1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = PTR_W'(i);
        win_hit = 1'b1;
      end
    end
    for (int i = NUM_IN-1; i >= 0; i--) begin
      if (hi_mask[i]) win_idx = PTR_W'(i);
    end
  end

  assign next_ptr  = (win_idx == PTR_W'(NUM_IN-1)) ? '0 : win_idx + PTR_W'(1);
  assign arb_go    = (state == ST_IDLE) && win_hit && free_outbound;
  assign last_byte = (byte_cnt == CNT_W'(PKT_BYTES-1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      byte_cnt   <= '0;
      sh_reg     <= '0;
      grant      <= '0;
      sent_count <= '0;
    end else begin
      grant <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_go) begin
            state    <= ST_SEND;
            sh_reg   <= pkt_arr[win_idx];
            ptr      <= next_ptr;
            byte_cnt <= '0;
            grant    <= NUM_IN'(1) << win_idx;
          end
        end
        default: begin
          // Inputs and free_outbound are not looked at here: the packet is
          // already latched and downstream space was promised up front.
          sh_reg   <= sh_reg << 8;
          byte_cnt <= byte_cnt + CNT_W'(1);
          if (last_byte) begin
            state      <= ST_IDLE;
            sent_count <= sent_count + 16'd1;
          end
        end
      endcase
    end
  end

  // Decoded from registered state so async reset clears them immediately.
  assign busy             = (state == ST_SEND);
  assign put_outbound     = busy;
  assign payload_outbound = busy ? sh_reg[PKT_W-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
module tb_noc_out_port_arbiter;
  localparam int NUM_IN    = 4;
  localparam int PKT_BYTES = 4;
  localparam int PKT_W     = 32;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_IN-1:0]       req;
  logic [NUM_IN*PKT_W-1:0] req_pkt;
  logic [NUM_IN-1:0]       grant;
  logic                    free_outbound;
  logic                    put_outbound;
  logic [7:0]              payload_outbound;
  logic                    busy;
  logic [15:0]             sent_count;

  int errs   = 0;
  int checks = 0;

  noc_out_port_arbiter #(.NUM_IN(NUM_IN), .PKT_BYTES(PKT_BYTES)) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .req_pkt          (req_pkt),
    .grant            (grant),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .busy             (busy),
    .sent_count       (sent_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Waits for a grant (bounded), then checks grant, every byte, and the
  // idle cycle after. Returns at the negedge of that idle cycle.
  task automatic send_check(input string tag, input logic [3:0] eg,
                            input logic [31:0] pkt, input bit drop,
                            input bit kill_free);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (grant == '0 && n < 40);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_grant"}, grant, eg);
    if (drop) req = req & ~eg;
    for (int b = 0; b < PKT_BYTES; b++) begin
      if (b > 0) begin
        @(negedge clock);
        chk({tag, "_gnt_low"}, grant, 0);
      end
      chk({tag, "_put"}, put_outbound, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_byte"}, payload_outbound, pkt[31-8*b -: 8]);
      if (kill_free && b == 1) free_outbound = 1'b0;
    end
    @(negedge clock);
    chk({tag, "_put_end"}, put_outbound, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_pay_end"}, payload_outbound, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [31:0] pk [4];

  initial begin
    pk[0] = 32'hA1B2C3D4;
    pk[1] = 32'h11223344;
    pk[2] = 32'h55667788;
    pk[3] = 32'h99AABBCC;
    reset = 1'b1;
    req = '0;
    free_outbound = 1'b0;
    req_pkt = '0;
    for (int i = 0; i < NUM_IN; i++) req_pkt[i*PKT_W +: PKT_W] = pk[i];
    repeat (2) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_put", put_outbound, 0);
    chk("rst_pay", payload_outbound, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sent_count, 0);
    reset = 1'b0;

    // single packet from buffer 0
    @(negedge clock);
    req = 4'b0001;
    free_outbound = 1'b1;
    send_check("t1", 4'b0001, pk[0], 1'b1, 1'b0);
    chk("t1_cnt", sent_count, 1);

    // all requesting: strict rotation, back-to-back at 5-cycle spacing
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++)
      send_check("t2", 4'(1 << (k % 4)), pk[k % 4], 1'b0, 1'b0);
    req = 4'b0000;
    chk("t2_cnt", sent_count, 8);

    // ptr=0 after granting 3: 1 wins before 3
    req = 4'b1010;
    send_check("t5a", 4'b0010, pk[1], 1'b1, 1'b0);
    send_check("t5b", 4'b1000, pk[3], 1'b1, 1'b0);
    chk("t5_cnt", sent_count, 10);

    // held off by free_outbound=0
    free_outbound = 1'b0;
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("t3_nogrant", grant, 0);
      chk("t3_noput", put_outbound, 0);
    end
    free_outbound = 1'b1;
    send_check("t3", 4'b0100, pk[2], 1'b1, 1'b0);

    // ptr=3, only req[0]: wraps. free drops mid-packet, packet completes
    req = 4'b0001;
    send_check("t4a", 4'b0001, pk[0], 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t4_hold", grant, 0);
      chk("t4_hold_put", put_outbound, 0);
    end
    free_outbound = 1'b1;
    send_check("t4b", 4'b0001, pk[0], 1'b1, 1'b0);
    chk("t4_cnt", sent_count, 13);

    // reset during third byte
    req = 4'b0100;
    @(negedge clock);
    chk("t6_grant", grant, 4'b0100);
    req = 4'b0000;
    @(negedge clock);
    @(negedge clock);
    chk("t6_mid_put", put_outbound, 1);
    chk("t6_mid_byte", payload_outbound, 8'h77);
    reset = 1'b1;
    #1;
    chk("t6_rst_put", put_outbound, 0);
    chk("t6_rst_pay", payload_outbound, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_cnt", sent_count, 0);
    @(negedge clock);
    reset = 1'b0;
    // ptr back at 0: with 1 and 3 requesting, 1 must win
    req = 4'b1010;
    send_check("t6", 4'b0010, pk[1], 1'b1, 1'b0);
    req = 4'b0000;
    chk("t6_cnt", sent_count, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
